spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Register bank and SPI master engine sitting directly downstream of the AXI-Lite slave interface. Consumes its write data bus and per-register write strobes (control at 0x00, data at 0x08), and returns the control, status and data register values it reads back. Runs one full-duplex, fixed-length SPI frame per START command. SCLK rate, polarity and phase are programmable.

## Interface
- DATA_W, 8, frame length in bits (1..32); MSB first
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- i_data_to_registers  in  32  write data from AXI slave
- i_wr_controll_reg  in  1  one-cycle write strobe, control register
- i_wr_data_reg  in  1  one-cycle write strobe, data register
- o_controll_reg  out  32  control register readback
- o_status_reg  out  32  status register readback
- o_data_reg  out  32  last received frame, zero-extended
- spi_sclk  out  1  serial clock
- spi_mosi  out  1  master out
- spi_miso  in  1  master in
- spi_cs_n  out  1  chip select, active-low

## Operation
- Control fields:
  - [0] START, write-only, reads 0.
  - [1] CPOL.
  - [2] CPHA.
  - [3] CS_HOLD: keep cs_n low after the frame.
  - [4] LOOPBACK: see Configuration.
  - [15:8] CLKDIV: N.
  - Other bits read 0.
- Status fields:
  - [0] BUSY.
  - [1] DONE, sticky.
  - [2] OVERRUN, sticky.
  - Other bits 0.
- Data write loads the TX buffer from i_data_to_registers[DATA_W-1:0].
- Data read returns the RX register.
- Reset values:
  - Control = 0, status = 0, TX = 0, RX = 0.
  - spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0, state IDLE.
- FSM states are IDLE, SETUP, XFER, HOLD.
- IDLE: control write stores fields [15:1]. spi_sclk follows CPOL. If START=1:
  - Go to SETUP.
  - Load the shift register from TX.
  - Drive spi_cs_n=0 and BUSY=1.
  - Clear DONE and OVERRUN.
- SETUP: N+1 cycles, then XFER. When CPHA=0, MOSI carries the MSB during SETUP.
- XFER: 2*DATA_W half-periods, each N+1 cycles.
  - Each half-period ends by toggling SCLK.
  - The leading edge is the first edge of each bit; the trailing edge is the second.
  - CPHA=0: sample MISO on the leading edge; shift MOSI on the trailing edge.
  - CPHA=1: shift MOSI on the leading edge; sample MISO on the trailing edge.
- HOLD: N+1 cycles, then IDLE.
  - RX is written from the shift register.
  - BUSY=0 and DONE=1.
  - spi_cs_n=1 unless CS_HOLD=1.
- A START issued while cs_n is held low begins a new frame without deasserting cs_n.
- Writes while BUSY:
  - A control write is ignored entirely.
  - A data write is ignored and sets OVERRUN.
- Simultaneous control and data strobes in IDLE: TX loads first, and START uses the new value.
- CS_HOLD=0 written in IDLE releases a held cs_n on the next cycle.

## Timing
- Readback outputs are registered. A write strobe at edge T is visible on the outputs after edge T.
- Busy duration is (N+1)*(2*DATA_W+2) cycles. N=0 with DATA_W=8 gives 18 cycles.
- spi_cs_n falls at the same edge that sets BUSY.
- spi_sclk changes only in XFER. It returns to CPOL at the end of XFER.
- SCLK half-period is (N+1) clk cycles. N=255 gives a 512-cycle period.
- Bit counter and divider wrap cleanly: no extra edge after the last bit.
- Reset mid-frame at edge T:
  - All outputs take their reset values after T.
  - No DONE; RX is unchanged at 0.

## Configuration
- SPI_LOOPBACK_EN defined:
  - Control bit 4 is implemented.
  - When set, the sampled bit is the internal MOSI and spi_miso is ignored.
  - spi_mosi is still driven.
- SPI_LOOPBACK_EN undefined:
  - Bit 4 is not stored and reads 0.
  - The sampled bit is always spi_miso.

## Test plan
- Reset, then read all three registers:
  - Control, status and data read 0x00000000.
  - spi_cs_n=1, spi_sclk=0.
- Mode 0, N=0: write TX=0xA5, then control=0x00000001. A slave model returns 0x3C.
  - MOSI bits on rising edges are 1,0,1,0,0,1,0,1.
  - BUSY is high for 18 cycles.
  - Status reads 0x2 and data reads 0x0000003C.
- Mode 3 (CPOL=1, CPHA=1), N=3: control=0x0307, slave returns 0x81.
  - SCLK idles high with a period of 8 cycles.
  - BUSY is high for 72 cycles.
  - Data reads 0x81.
- Data write while BUSY:
  - OVERRUN is set and the frame's MOSI is unchanged.
  - The next START clears OVERRUN and DONE.
- CS_HOLD=1 with two back-to-back frames:
  - spi_cs_n stays low across both frames.
  - Writing control=0 releases cs_n one cycle later.
- Reset asserted in the middle of XFER:
  - Next cycle: cs_n=1, sclk=0, status=0.
  - With SPI_LOOPBACK_EN defined, a loopback frame of 0x5A returns 0x5A.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master with control/status/data register bank fed by AXI-Lite write strobes.
// Define SPI_LOOPBACK_EN to implement control bit 4 (internal MOSI->MISO loopback).
module spi_master_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_data_to_registers,
  input  logic        i_wr_controll_reg,
  input  logic        i_wr_data_reg,
  output logic [31:0] o_controll_reg,
  output logic [31:0] o_status_reg,
  output logic [31:0] o_data_reg,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  localparam int unsigned HALF_W = $clog2(2 * DATA_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_cs_hold;
  logic              r_loop;
  logic [7:0]        r_clkdiv;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_shift;
  logic              r_sample;
  logic              r_mosi;
  logic              r_sclk;
  logic              r_cs_n;
  logic [7:0]        r_div;
  logic [HALF_W-1:0] r_half;

  logic              w_div_end;
  logic              w_last_half;
  logic              w_start;
  logic              w_miso;
  logic              w_loop_wr;
  logic [DATA_W-1:0] w_tx_src;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_unused;

  assign w_div_end    = (r_div == r_clkdiv);
  assign w_last_half  = (r_half == HALF_W'(2 * DATA_W - 1));
  assign w_start      = i_wr_controll_reg && i_data_to_registers[0];
  // A data write in the same cycle as START feeds the new value straight into the frame.
  assign w_tx_src     = i_wr_data_reg ? i_data_to_registers[DATA_W-1:0] : r_tx;
  assign w_shift_next = DATA_W'({r_shift, r_sample});
  assign w_unused     = ^i_data_to_registers[31:16];

`ifdef SPI_LOOPBACK_EN
  assign w_loop_wr = i_data_to_registers[4];
  assign w_miso    = r_loop ? r_mosi : spi_miso;
`else
  assign w_loop_wr = 1'b0;
  assign w_miso    = spi_miso;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_SETUP;
      S_SETUP: if (w_div_end) w_state_next = S_XFER;
      S_XFER:  if (w_div_end && w_last_half) w_state_next = S_HOLD;
      S_HOLD:  if (w_div_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_cs_hold <= 1'b0;
      r_loop    <= 1'b0;
      r_clkdiv  <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_shift   <= '0;
      r_sample  <= 1'b0;
      r_mosi    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_div     <= 8'd0;
      r_half    <= '0;
    end else if (r_state == S_IDLE) begin
      r_sclk <= r_cpol;
      if (i_wr_data_reg) r_tx <= i_data_to_registers[DATA_W-1:0];
      if (i_wr_controll_reg) begin
        r_cpol    <= i_data_to_registers[1];
        r_cpha    <= i_data_to_registers[2];
        r_cs_hold <= i_data_to_registers[3];
        r_loop    <= w_loop_wr;
        r_clkdiv  <= i_data_to_registers[15:8];
        r_sclk    <= i_data_to_registers[1];
        if (w_start) begin
          r_shift   <= w_tx_src;
          r_mosi    <= i_data_to_registers[2] ? 1'b0 : w_tx_src[DATA_W-1];
          r_cs_n    <= 1'b0;
          r_busy    <= 1'b1;
          r_done    <= 1'b0;
          r_overrun <= 1'b0;
          r_div     <= 8'd0;
          r_half    <= '0;
        end else if (!i_data_to_registers[3]) begin
          r_cs_n <= 1'b1;
        end
      end
    end else begin
      // Busy: control writes are dropped, data writes only flag the overrun.
      if (i_wr_data_reg) r_overrun <= 1'b1;
      if (!w_div_end) begin
        r_div <= r_div + 8'd1;
      end else begin
        r_div <= 8'd0;
        if (r_state == S_XFER) begin
          r_sclk <= ~r_sclk;
          r_half <= w_last_half ? '0 : r_half + HALF_W'(1);
          if (!r_half[0]) begin
            if (r_cpha) r_mosi   <= r_shift[DATA_W-1];
            else        r_sample <= w_miso;
          end else begin
            r_shift <= r_cpha ? DATA_W'({r_shift, w_miso}) : w_shift_next;
            if (!r_cpha) r_mosi <= w_shift_next[DATA_W-1];
          end
        end else if (r_state == S_HOLD) begin
          r_rx   <= r_shift;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cs_n <= ~r_cs_hold;
          r_mosi <= 1'b0;
        end
      end
    end
  end

  assign o_controll_reg = {16'd0, r_clkdiv, 3'd0, r_loop, r_cs_hold, r_cpha, r_cpol, 1'b0};
  assign o_status_reg   = {29'd0, r_overrun, r_done, r_busy};
  assign o_data_reg     = 32'(r_rx);
  assign spi_sclk       = r_sclk;
  assign spi_mosi       = r_mosi;
  assign spi_cs_n       = r_cs_n;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl with a byte-wide SPI slave model.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_data_to_registers;
  logic        i_wr_controll_reg;
  logic        i_wr_data_reg;
  logic [31:0] o_controll_reg;
  logic [31:0] o_status_reg;
  logic [31:0] o_data_reg;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs_n;

  int n_checks = 0;
  int n_fail   = 0;

  spi_master_ctrl #(.DATA_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_data_to_registers (i_data_to_registers),
    .i_wr_controll_reg   (i_wr_controll_reg),
    .i_wr_data_reg       (i_wr_data_reg),
    .o_controll_reg      (o_controll_reg),
    .o_status_reg        (o_status_reg),
    .o_data_reg          (o_data_reg),
    .spi_sclk            (spi_sclk),
    .spi_mosi            (spi_mosi),
    .spi_miso            (spi_miso),
    .spi_cs_n            (spi_cs_n)
  );

  always #5 clk = ~clk;

  // Slave model: configured by the stimulus, re-armed whenever s_gen changes.
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  int         s_gen = 0;
  int         s_seen = 0;
  int         s_idx = 8;

  assign spi_miso = (s_idx >= 0 && s_idx < 8) ? s_tx[3'(7 - s_idx)] : 1'b0;

  always @(spi_sclk or s_gen) begin
    if (s_gen != s_seen) begin
      s_seen = s_gen;
      s_idx  = s_cpha ? -1 : 0;
      s_rx   = 8'h00;
    end else if (spi_cs_n === 1'b0) begin
      if (spi_sclk != s_cpol) begin
        if (!s_cpha) s_rx = {s_rx[6:0], spi_mosi};
        else         s_idx++;
      end else begin
        if (!s_cpha) s_idx++;
        else         s_rx = {s_rx[6:0], spi_mosi};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_data(input logic [31:0] v);
    i_data_to_registers = v;
    i_wr_data_reg = 1'b1;
    tick();
    i_wr_data_reg = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    i_data_to_registers = v;
    i_wr_controll_reg = 1'b1;
    tick();
    i_wr_controll_reg = 1'b0;
  endtask

  task automatic arm(input logic [7:0] v, input logic cpol, input logic cpha);
    s_tx   = v;
    s_cpol = cpol;
    s_cpha = cpha;
    s_gen++;
    #1;
  endtask

  // Runs until BUSY drops (bounded); reports busy cycles, SCLK toggles, SCLK period and any cs_n rise.
  task automatic run_frame(output int busy_n, output int toggles, output int period, output bit cs_rose);
    int   t1;
    logic prev;
    busy_n = 0; toggles = 0; period = 0; cs_rose = 1'b0; t1 = 0;
    prev = spi_sclk;
    while (o_status_reg[0] === 1'b1 && busy_n < 5000) begin
      busy_n++;
      if (spi_cs_n !== 1'b0) cs_rose = 1'b1;
      tick();
      if (spi_sclk !== prev) begin
        toggles++;
        if (toggles == 1) t1 = busy_n;
        if (toggles == 3) period = busy_n - t1;
        prev = spi_sclk;
      end
    end
  endtask

  int busy_n, toggles, period;
  bit cs_rose;

  initial begin
    reset = 1'b1;
    i_data_to_registers = 32'd0;
    i_wr_controll_reg = 1'b0;
    i_wr_data_reg = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ctrl", o_controll_reg, 32'h0);
    check("rst_status", o_status_reg, 32'h0);
    check("rst_data", o_data_reg, 32'h0);
    check("rst_cs_n", 32'(spi_cs_n), 32'h1);
    check("rst_sclk", 32'(spi_sclk), 32'h0);
    check("rst_mosi", 32'(spi_mosi), 32'h0);

    // Mode 0, N=0
    arm(8'h3C, 1'b0, 1'b0);
    wr_data(32'h0000_00A5);
    check("m0_data_before", o_data_reg, 32'h0);
    wr_ctrl(32'h0000_0001);
    check("m0_busy_set", o_status_reg, 32'h1);
    check("m0_cs_low", 32'(spi_cs_n), 32'h0);
    check("m0_ctrl_rd", o_controll_reg, 32'h0);
    run_frame(busy_n, toggles, period, cs_rose);
    check("m0_busy_cycles", 32'(busy_n), 32'd18);
    check("m0_toggles", 32'(toggles), 32'd16);
    check("m0_period", 32'(period), 32'd2);
    check("m0_status", o_status_reg, 32'h2);
    check("m0_data", o_data_reg, 32'h3C);
    check("m0_mosi_bits", 32'(s_rx), 32'hA5);
    check("m0_cs_high", 32'(spi_cs_n), 32'h1);
    check("m0_sclk_idle", 32'(spi_sclk), 32'h0);

    // Mode 3, N=3
    wr_ctrl(32'h0000_0306);
    check("m3_sclk_idle_hi", 32'(spi_sclk), 32'h1);
    arm(8'h81, 1'b1, 1'b1);
    wr_ctrl(32'h0000_0307);
    check("m3_ctrl_rd", o_controll_reg, 32'h0306);
    check("m3_sclk_start", 32'(spi_sclk), 32'h1);
    run_frame(busy_n, toggles, period, cs_rose);
    check("m3_busy_cycles", 32'(busy_n), 32'd72);
    check("m3_toggles", 32'(toggles), 32'd16);
    check("m3_period", 32'(period), 32'd8);
    check("m3_data", o_data_reg, 32'h81);
    check("m3_mosi_bits", 32'(s_rx), 32'hA5);
    check("m3_sclk_end", 32'(spi_sclk), 32'h1);
    check("m3_status", o_status_reg, 32'h2);

    // Writes while busy
    wr_ctrl(32'h0000_0000);
    arm(8'h99, 1'b0, 1'b0);
    wr_data(32'h0000_00C3);
    wr_ctrl(32'h0000_0001);
    repeat (3) tick();
    wr_data(32'h0000_00FF);
    check("ovr_status_busy", o_status_reg, 32'h5);
    wr_ctrl(32'h0000_0F06);
    check("ovr_ctrl_ignored", o_controll_reg, 32'h0);
    run_frame(busy_n, toggles, period, cs_rose);
    check("ovr_mosi_bits", 32'(s_rx), 32'hC3);
    check("ovr_status_done", o_status_reg, 32'h6);
    check("ovr_data", o_data_reg, 32'h99);
    arm(8'h12, 1'b0, 1'b0);
    wr_ctrl(32'h0000_0001);
    check("ovr_start_clears", o_status_reg, 32'h1);
    run_frame(busy_n, toggles, period, cs_rose);
    check("ovr_tx_kept", 32'(s_rx), 32'hC3);
    check("ovr_status2", o_status_reg, 32'h2);
    check("ovr_data2", o_data_reg, 32'h12);

    // CS_HOLD back-to-back
    arm(8'h55, 1'b0, 1'b0);
    wr_ctrl(32'h0000_0009);
    check("hold1_cs_low", 32'(spi_cs_n), 32'h0);
    run_frame(busy_n, toggles, period, cs_rose);
    check("hold1_cs_rose", 32'(cs_rose), 32'h0);
    check("hold1_busy", 32'(busy_n), 32'd18);
    check("hold1_cs_after", 32'(spi_cs_n), 32'h0);
    check("hold1_ctrl", o_controll_reg, 32'h8);
    check("hold1_data", o_data_reg, 32'h55);
    tick();
    check("hold_gap_cs", 32'(spi_cs_n), 32'h0);
    arm(8'hAA, 1'b0, 1'b0);
    wr_ctrl(32'h0000_0009);
    run_frame(busy_n, toggles, period, cs_rose);
    check("hold2_cs_rose", 32'(cs_rose), 32'h0);
    check("hold2_data", o_data_reg, 32'hAA);
    check("hold2_mosi_bits", 32'(s_rx), 32'hC3);
    check("hold2_cs_after", 32'(spi_cs_n), 32'h0);
    wr_ctrl(32'h0000_0000);
    check("hold_release", 32'(spi_cs_n), 32'h1);

    // Reset during XFER
    arm(8'h77, 1'b0, 1'b0);
    wr_ctrl(32'h0000_0301);
    repeat (10) tick();
    check("rstx_busy", o_status_reg, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstx_cs_n", 32'(spi_cs_n), 32'h1);
    check("rstx_sclk", 32'(spi_sclk), 32'h0);
    check("rstx_status", o_status_reg, 32'h0);
    check("rstx_ctrl", o_controll_reg, 32'h0);
    check("rstx_data", o_data_reg, 32'h0);
    check("rstx_mosi", 32'(spi_mosi), 32'h0);
    repeat (5) tick();
    check("rstx_no_done", o_status_reg, 32'h0);
    check("rstx_data_late", o_data_reg, 32'h0);

    // Loopback request: honoured only when the feature is built in
    arm(8'hFF, 1'b0, 1'b0);
    wr_data(32'h0000_005A);
    wr_ctrl(32'h0000_0011);
`ifdef SPI_LOOPBACK_EN
    check("lb_ctrl", o_controll_reg, 32'h10);
`else
    check("lb_ctrl", o_controll_reg, 32'h0);
`endif
    run_frame(busy_n, toggles, period, cs_rose);
    check("lb_busy", 32'(busy_n), 32'd18);
`ifdef SPI_LOOPBACK_EN
    check("lb_data", o_data_reg, 32'h5A);
`else
    check("lb_data", o_data_reg, 32'hFF);
`endif
    check("lb_mosi_bits", 32'(s_rx), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
